// File: rtl/sigmoid_eval_ctrl.sv
// Sequencer for one stochastic sigmoid datapath: clears it, streams an LFSR-compared
// bitstream into it, and counts output ones over a fixed window.
module sigmoid_eval_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STREAM_LEN   = 255,
    parameter int unsigned WARMUP       = 16,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned LFSR_SEED    = 1,
    localparam int unsigned CW          = $clog2(STREAM_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             busy,
    output logic             dp_n_rst,
    output logic             dp_x,
    input  logic             dp_y
);

    localparam int unsigned PMAX0 = (CLEAR_CYCLES > WARMUP) ? CLEAR_CYCLES : WARMUP;
    localparam int unsigned PMAX  = (PMAX0 > STREAM_LEN) ? PMAX0 : STREAM_LEN;
    localparam int unsigned PW    = $clog2(PMAX + 1);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);
    // Feedback taps: x^8+x^6+x^5+x^4+1 or x^16+x^14+x^13+x^11+1
    localparam logic [WIDTH-1:0] TAPS = (WIDTH == 16) ? WIDTH'(32'h0000_B400)
                                                      : WIDTH'(32'h0000_00B8);

    if (!(WIDTH == 8 || WIDTH == 16)) begin : g_bad_width
        $error("sigmoid_eval_ctrl: WIDTH must be 8 or 16");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("sigmoid_eval_ctrl: LFSR_SEED must be nonzero");
    end
    if (STREAM_LEN < 1 || CLEAR_CYCLES < 1) begin : g_bad_len
        $error("sigmoid_eval_ctrl: STREAM_LEN and CLEAR_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    phase;
    logic             boot;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] lfsr_nxt;

    always_comb lfsr_nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLEAR;
            phase     <= '0;
            boot      <= 1'b1;
            lfsr      <= SEED;
            value     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            busy      <= 1'b1;
            dp_n_rst  <= 1'b0;
            dp_x      <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (phase == PW'(CLEAR_CYCLES - 1)) begin
                        phase    <= '0;
                        dp_n_rst <= 1'b1;
                        if (boot) begin
                            // First clear after reset parks in IDLE instead of streaming
                            boot     <= 1'b0;
                            state    <= S_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state <= (WARMUP == 0) ? S_RUN : S_WARMUP;
                            dp_x  <= (lfsr < value);
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        value     <= in_value;
                        lfsr      <= SEED;
                        out_count <= '0;
                        state     <= S_CLEAR;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        dp_n_rst  <= 1'b0;
                    end
                end
                S_WARMUP: begin
                    lfsr <= lfsr_nxt;
                    dp_x <= (lfsr_nxt < value);
                    if (phase == PW'(WARMUP - 1)) begin
                        phase <= '0;
                        state <= S_RUN;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                S_RUN: begin
                    out_count <= out_count + CW'(dp_y);
                    if (phase == PW'(STREAM_LEN - 1)) begin
                        phase     <= '0;
                        state     <= S_DONE;
                        dp_x      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        phase <= phase + PW'(1);
                        lfsr  <= lfsr_nxt;
                        dp_x  <= (lfsr_nxt < value);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_CLEAR;
                    phase     <= '0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                    dp_n_rst  <= 1'b0;
                    dp_x      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sigmoid_eval_ctrl.md
Name: sigmoid_eval_ctrl

Overview:
- Sequencer for one stochastic sigmoid datapath instance. It accepts a binary operand over a valid/ready handshake.
- It clears the datapath, then drives the datapath input bitstream from an internal LFSR stochastic number generator (SNG).
- After a warm-up period it counts output ones over a fixed stream window and returns the count over a valid/ready handshake.
- Sits between the binary host/pipeline side and the bitstream network.

Parameters:
- WIDTH, 8, operand and LFSR width; only 8 and 16 are legal.
- STREAM_LEN, 255, counted window length in cycles, >=1.
- WARMUP, 16, cycles streamed but not counted, >=0.
- CLEAR_CYCLES, 2, cycles the datapath reset is held per evaluation, >=1.
- LFSR_SEED, 1, nonzero LFSR seed loaded at every evaluation start.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  controller can accept an operand
- in_value  in  WIDTH  operand v (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_count  out  CW  ones counted; CW = $clog2(STREAM_LEN+1)
- busy  out  1  high in every state except IDLE
- dp_n_rst  out  1  active-low reset to the sigmoid datapath
- dp_x  out  1  input bitstream to the datapath
- dp_y  in  1  output bitstream from the datapath

Behaviour:
- States: CLEAR, IDLE, WARMUP, RUN, DONE. All outputs are registered or decoded from the state only; there is no combinational in-to-out path.
- Reset (async): state=CLEAR, phase counter=0, in_ready=0, out_valid=0, out_count=0, dp_x=0, dp_n_rst=0, busy=1, LFSR=LFSR_SEED. When rst deasserts, CLEAR runs its normal length, so the datapath is always cleared after reset.
- CLEAR: dp_n_rst=0, dp_x=0. After CLEAR_CYCLES edges, go to IDLE the first time after reset, otherwise to WARMUP (WARMUP=0 goes straight to RUN).
- IDLE: in_ready=1, dp_n_rst=1, dp_x=0. On an edge with in_valid&in_ready: latch v, load LFSR=LFSR_SEED, clear the ones counter, go to CLEAR.
- WARMUP: dp_n_rst=1, dp_x = (lfsr < v) unsigned compare; LFSR steps every edge. After WARMUP edges, go to RUN.
- RUN: same dp_x/LFSR behaviour as WARMUP. The ones counter increments on each edge where dp_y=1. After STREAM_LEN edges, go to DONE; the edge that leaves RUN still samples dp_y.
- DONE: out_valid=1, out_count holds the final count and is stable while out_valid&!out_ready. dp_x=0, dp_n_rst=1. On out_valid&out_ready, go to IDLE; in_ready rises on the next cycle.
- Latency: out_valid rises exactly CLEAR_CYCLES+WARMUP+STREAM_LEN edges after the accepting edge.
- LFSR is Fibonacci, shift-left, feedback into bit0:
  - WIDTH=8: x^8+x^6+x^5+x^4+1, period 255.
  - WIDTH=16: x^16+x^14+x^13+x^11+1, period 65535.
  - It never holds 0.
- Counter saturation cannot occur because CW covers STREAM_LEN.
- in_valid outside IDLE is ignored and not buffered. in_value is sampled only on the accept edge; later changes have no effect.
- rst asserted mid-evaluation aborts immediately, with no result and out_valid=0. This includes mid-DONE.
- Illegal WIDTH or LFSR_SEED=0 fails elaboration via an assertion.

Test Plan:
- Reset release, defaults: dp_n_rst=0 for exactly 2 cycles after release, then in_ready=1 and busy=0. in_value changing while idle causes no dp_x activity.
- Stub dp_y=dp_x, defaults, v=128: out_count=127. With v=0: out_count=0, dp_x never 1. With v=255: out_count=254. All counts are exact because the window is one full LFSR period.
- Stub dp_y=1, v=10, STREAM_LEN=100, WARMUP=0: out_count=100, and out_valid rises exactly 102 edges after accept.
- Backpressure: hold out_ready=0 for 20 cycles in DONE. out_count stays stable, in_ready=0, and in_valid pulses are ignored. Release gives one result and in_ready rises the following cycle. Back-to-back operands produce distinct, correct results.
- Assert rst mid-RUN, v=200: out_valid=0, dp_n_rst=0 immediately. After release, CLEAR then IDLE, and a new evaluation with v=128 returns 127.
- Determinism: two evaluations with the same v give identical dp_x sequences cycle for cycle, since the LFSR is reseeded each time.
